// File: rtl/store_write_buffer.sv
// Posted-store write buffer: in-order FIFO of word stores that merges consecutive
// stores to the same word, drains over mem_req/mem_ack and flags load hazards.
module store_write_buffer #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 30,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    // Store side. st_ready never depends on st_valid; a store is taken on any
    // edge where st_valid & st_ready are both high.
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_waddr,
    input  logic [31:0]   st_data,
    input  logic [3:0]    st_bwe,
    input  logic          ld_check,
    input  logic [AW-1:0] ld_waddr,
    output logic          ld_hazard,
    // Memory side. mem_req holds the head entry stable until an edge with mem_ack.
    output logic          mem_req,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_bwe,
    input  logic          mem_ack,
    output logic [CW-1:0] count,
    output logic          drained,
    output logic          state_dbg
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_waddr [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic [3:0]    r_bwe   [DEPTH];

    logic [PW-1:0] w_newest;
    logic          w_issue;
    logic          w_full;
    logic          w_coalesce;
    logic          w_accept;
    logic          w_push;
    logic          w_merge;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_merge_data;
    logic [PW-1:0] w_off [DEPTH];
    logic          w_hazard;

    assign w_newest = r_tail - PW'(1);
    assign w_issue  = (r_state == S_ISSUE);
    assign w_full   = (r_count == CW'(DEPTH));

    // The head being presented to memory must stay stable, so it is never a merge target.
    assign w_coalesce = (r_count != '0) && (r_waddr[w_newest] == st_waddr) &&
                        !((w_newest == r_head) && w_issue);

    assign st_ready    = !w_full || w_coalesce;
    assign w_accept    = st_valid && st_ready && (st_bwe != 4'b0000);
    assign w_merge     = w_accept && w_coalesce;
    assign w_push      = w_accept && !w_coalesce;
    assign w_pop       = w_issue && mem_ack;
    assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

    always_comb begin
        w_merge_data = r_data[w_newest];
        for (int i = 0; i < 4; i++) begin
            if (st_bwe[i]) begin
                w_merge_data[8*i +: 8] = st_data[8*i +: 8];
            end
        end
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = PW'(i) - r_head;
            if (({1'b0, w_off[i]} < r_count) && (r_waddr[i] == ld_waddr)) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr[r_tail] <= st_waddr;
            r_data[r_tail]  <= st_data;
            r_bwe[r_tail]   <= st_bwe;
        end else if (w_merge) begin
            r_data[w_newest] <= w_merge_data;
            r_bwe[w_newest]  <= r_bwe[w_newest] | st_bwe;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= w_count_nxt;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A push in the ack cycle keeps the drain going without a bubble.
                    if (w_pop && (w_count_nxt == '0)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = w_issue;
    assign mem_waddr = w_issue ? r_waddr[r_head] : '0;
    assign mem_wdata = w_issue ? r_data[r_head]  : '0;
    assign mem_bwe   = w_issue ? r_bwe[r_head]   : '0;
    assign ld_hazard = ld_check && w_hazard;
    assign count     = r_count;
    assign drained   = (r_count == '0) && !w_issue;
    assign state_dbg = w_issue;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 30;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_waddr;
    logic [31:0]   st_data;
    logic [3:0]    st_bwe;
    logic          ld_check;
    logic [AW-1:0] ld_waddr;
    logic          ld_hazard;
    logic          mem_req;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_bwe;
    logic          mem_ack;
    logic [2:0]    count;
    logic          drained;
    logic          state_dbg;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_waddr(st_waddr),
        .st_data(st_data), .st_bwe(st_bwe),
        .ld_check(ld_check), .ld_waddr(ld_waddr), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_bwe(mem_bwe), .mem_ack(mem_ack),
        .count(count), .drained(drained), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [31:0]   data;
        logic [3:0]    bwe;
    } ent_t;

    ent_t m_q[$];
    bit   m_busy = 1'b0;
    bit   m_live = 1'b0;

    function automatic bit m_hit();
        if (m_q.size() == 0) return 1'b0;
        if (m_q[m_q.size()-1].waddr != st_waddr) return 1'b0;
        return !(m_q.size() == 1 && m_busy);
    endfunction

    always @(posedge clk) begin : model_update
        bit   hit;
        bit   rdy;
        bit   pop;
        bit   was_busy;
        int   sz0;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_busy = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            hit      = m_hit();
            rdy      = (m_q.size() < DEPTH) || hit;
            pop      = m_busy && mem_ack;
            was_busy = m_busy;
            sz0      = m_q.size();
            if (pop) e = m_q.pop_front();
            if (st_valid && rdy && st_bwe != 4'b0000) begin
                if (hit) begin
                    e = m_q[m_q.size()-1];
                    for (int i = 0; i < 4; i++)
                        if (st_bwe[i]) e.data[8*i +: 8] = st_data[8*i +: 8];
                    e.bwe = e.bwe | st_bwe;
                    m_q[m_q.size()-1] = e;
                end else begin
                    e.waddr = st_waddr;
                    e.data  = st_data;
                    e.bwe   = st_bwe;
                    m_q.push_back(e);
                end
            end
            if (was_busy) m_busy = pop ? (m_q.size() > 0) : 1'b1;
            else          m_busy = (sz0 > 0);
        end
    end

    // Every cycle, compare all outputs against the model once inputs have settled.
    always @(negedge clk) begin : compare
        bit   e_hz;
        ent_t h;
        #2;
        if (m_live) begin
            e_hz = 1'b0;
            foreach (m_q[i]) if (m_q[i].waddr == ld_waddr) e_hz = 1'b1;
            h = m_busy ? m_q[0] : '0;
            chk("st_ready",  st_ready,  (m_q.size() < DEPTH) || m_hit());
            chk("ld_hazard", ld_hazard, ld_check && e_hz);
            chk("mem_req",   mem_req,   m_busy);
            chk("mem_waddr", mem_waddr, h.waddr);
            chk("mem_wdata", mem_wdata, h.data);
            chk("mem_bwe",   mem_bwe,   h.bwe);
            chk("count",     count,     m_q.size());
            chk("drained",   drained,   (m_q.size() == 0) && !m_busy);
            chk("state_dbg", state_dbg, m_busy);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic nxt();
        @(negedge clk);
        rst = 1'b0; st_valid = 1'b0; st_waddr = '0; st_data = '0; st_bwe = '0;
        ld_check = 1'b0; ld_waddr = '0; mem_ack = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = 1'b1; st_waddr = a; st_data = d; st_bwe = b;
    endtask

    task automatic settle();
        #3;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; st_valid = 1'b0; st_waddr = '0; st_data = '0; st_bwe = '0;
        ld_check = 1'b0; ld_waddr = '0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        nxt(); ld_check = 1'b1; ld_waddr = 30'h100; settle();
        chk("rst_count", count, 0); chk("rst_drained", drained, 1);
        chk("rst_req", mem_req, 0); chk("rst_hazard", ld_hazard, 0);

        // single store: one-cycle bubble before mem_req
        nxt(); push(30'h100, 32'hDEADBEEF, 4'b1111); settle(); chk("ss_ready", st_ready, 1);
        nxt(); settle(); chk("ss_count", count, 1); chk("ss_bubble", mem_req, 0);
        nxt(); mem_ack = 1'b1; settle();
        chk("ss_req", mem_req, 1); chk("ss_waddr", mem_waddr, 30'h100);
        chk("ss_wdata", mem_wdata, 32'hDEADBEEF); chk("ss_bwe", mem_bwe, 4'b1111);
        nxt(); settle(); chk("ss_req_off", mem_req, 0); chk("ss_drained", drained, 1);

        // coalesce, and no merge into the head while it is issuing
        nxt(); push(30'h20, 32'h12345678, 4'b1111);
        nxt();
        nxt(); push(30'h20, 32'h11111111, 4'b1111); settle();
        chk("co_issue", mem_req, 1); chk("co_cnt1", count, 1);
        nxt(); push(30'h10, 32'hAA000000, 4'b1000); settle(); chk("co_alloc", count, 2);
        nxt(); push(30'h10, 32'h000000BB, 4'b0001);
        nxt(); mem_ack = 1'b1; settle(); chk("co_merge_cnt", count, 3);
        chk("co_h0", mem_wdata, 32'h12345678);
        nxt(); mem_ack = 1'b1; settle(); chk("co_h1", mem_wdata, 32'h11111111);
        nxt(); mem_ack = 1'b1; settle();
        chk("co_h2_addr", mem_waddr, 30'h10); chk("co_h2_data", mem_wdata, 32'hAA0000BB);
        chk("co_h2_bwe", mem_bwe, 4'b1001);
        nxt(); settle(); chk("co_drained", drained, 1);

        // full
        nxt(); push(30'h1, 32'h01010101, 4'b1111);
        nxt(); push(30'h2, 32'h02020202, 4'b1111);
        nxt(); push(30'h3, 32'h03030303, 4'b1111);
        nxt(); push(30'h4, 32'h40404040, 4'b1101);
        nxt(); settle(); chk("fu_cnt", count, 4);
        push(30'h5, 32'h05050505, 4'b1111); settle(); chk("fu_noready", st_ready, 0);
        nxt(); settle(); chk("fu_cnt_hold", count, 4);
        push(30'h4, 32'h0000CD00, 4'b0010); settle(); chk("fu_merge_ready", st_ready, 1);
        nxt(); settle(); chk("fu_cnt_merge", count, 4);
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_ack = 1'b1; settle(); chk("fu_order", mem_waddr, i + 1);
        end
        chk("fu_last_data", mem_wdata, 32'h4040CD40); chk("fu_last_bwe", mem_bwe, 4'b1111);
        nxt(); settle(); chk("fu_drained", drained, 1);

        // load hazard
        nxt(); push(30'h44, 32'h44444444, 4'b1111); ld_check = 1'b1; ld_waddr = 30'h44;
        settle(); chk("hz_self", ld_hazard, 0);
        nxt(); ld_check = 1'b1; ld_waddr = 30'h44; settle(); chk("hz_hit", ld_hazard, 1);
        nxt(); ld_check = 1'b1; ld_waddr = 30'h45; mem_ack = 1'b1; settle();
        chk("hz_miss", ld_hazard, 0); chk("hz_issue", mem_req, 1);
        nxt(); ld_check = 1'b1; ld_waddr = 30'h44; settle(); chk("hz_after_ack", ld_hazard, 0);

        // back-to-back drain with a push during the middle ack
        nxt(); push(30'h301, 32'hA1A1A1A1, 4'b1111);
        nxt(); push(30'h302, 32'hA2A2A2A2, 4'b1111);
        nxt(); push(30'h303, 32'hA3A3A3A3, 4'b1111);
        nxt(); settle(); chk("bb_cnt", count, 3); chk("bb_req", mem_req, 1);
        nxt(); mem_ack = 1'b1; settle(); chk("bb_h0", mem_waddr, 30'h301);
        nxt(); mem_ack = 1'b1; push(30'h304, 32'hA4A4A4A4, 4'b1111); settle();
        chk("bb_h1", mem_waddr, 30'h302); chk("bb_cnt1", count, 2);
        nxt(); mem_ack = 1'b1; settle(); chk("bb_h2", mem_waddr, 30'h303); chk("bb_cnt2", count, 2);
        nxt(); mem_ack = 1'b1; settle(); chk("bb_h3", mem_waddr, 30'h304); chk("bb_req3", mem_req, 1);
        nxt(); settle(); chk("bb_drained", drained, 1);

        // zero byte enables are a no-op
        nxt(); push(30'h400, 32'hFFFFFFFF, 4'b0000);
        nxt(); settle(); chk("z_cnt", count, 0);
        nxt(); settle(); chk("z_req", mem_req, 0);

        // reset while issuing
        nxt(); push(30'h501, 32'h5, 4'b1111);
        nxt(); push(30'h502, 32'h6, 4'b1111);
        nxt(); push(30'h503, 32'h7, 4'b1111);
        nxt(); settle(); chk("ri_cnt", count, 3); chk("ri_req", mem_req, 1); rst = 1'b1;
        nxt(); settle(); chk("ri_req_off", mem_req, 0); chk("ri_cnt0", count, 0);
        chk("ri_drained", drained, 1);

        // pointer wrap over several push/pop pairs
        for (int k = 0; k < 6; k++) begin
            nxt(); push(30'h200 + k, 32'h01010101 * k, 4'b1111);
            nxt();
            nxt(); mem_ack = 1'b1; settle();
            chk("wr_addr", mem_waddr, 30'h200 + k); chk("wr_data", mem_wdata, 32'h01010101 * k);
        end

        // randomized traffic: first mostly backpressured, then mostly draining
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 800; c++) begin
                nxt();
                rst      = ($urandom_range(0, 399) == 0);
                st_valid = $urandom_range(0, 1);
                st_waddr = $urandom_range(0, 5);
                st_data  = $urandom;
                st_bwe   = $urandom_range(0, 15);
                mem_ack  = (ph == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
                ld_check = $urandom_range(0, 1);
                ld_waddr = $urandom_range(0, 6);
            end
        end

        nxt(); nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
